// File: rtl/clock_select_ctrl.sv
// clock_select_ctrl: drives the HS/LS clock switch request from CPU decode.
// Stalls the CPU until the switch confirms; enforces LS dwell and timeout.
module clock_select_ctrl #(
   parameter logic [7:0] RAM_TOP_PAGE = 8'h80,
   parameter logic [7:0] IO_PAGE_LO   = 8'hFC,
   parameter int         LS_MIN       = 1,
   parameter int         IO_HOLD      = 2,
   parameter int         ADDR_DLY     = 2,
   parameter int         TIMEOUT      = 255
) (
   input  logic        hs_ck_ip,
   input  logic        resetb,
   input  logic        ls_ck_ip,
   input  logic        cpu_ck_ip,
   input  logic [15:0] addr_ip,
   input  logic        vda_ip,
   input  logic        vpa_ip,
   input  logic        himem_ip,
   input  logic        shadow_en_ip,
   input  logic        selected_hs_ip,
   input  logic        selected_ls_ip,
   output logic        select_hs_op,
   output logic        rdy_op,
   output logic [1:0]  state_op,
   output logic        switch_err_op
);

   typedef enum logic [1:0] {
      HS_RUN = 2'd0,
      TO_LS  = 2'd1,
      LS_RUN = 2'd2,
      TO_HS  = 2'd3
   } state_t;

   localparam int HOLD_MAX = (LS_MIN > IO_HOLD) ? LS_MIN : IO_HOLD;
   localparam int HW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
   localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [HW-1:0] HOLD_LS  = HW'(LS_MIN);
   localparam logic [HW-1:0] HOLD_IO  = HW'(IO_HOLD);
   localparam logic [HW-1:0] HOLD_TOP = HW'(HOLD_MAX);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

   state_t              state;
   logic [2:0]          ls_sync;
   logic [2:0]          cpu_sync;
   logic [1:0]          shs_sync;
   logic [1:0]          sls_sync;
   logic                cpu_fall_r;
   logic [ADDR_DLY-1:0] dly;
   logic [HW-1:0]       hold_cnt;
   logic [TW-1:0]       tcnt;
   logic                io_l;

   logic       ls_rise;
   logic       cpu_fall;
   logic       decide;
   logic       hs_ok;
   logic       ls_ok;
   logic [7:0] page;
   logic       valid;
   logic       fast;
   logic       io;
   logic       unused_addr;

   assign ls_rise  = ls_sync[1] & ~ls_sync[2];
   assign cpu_fall = ~cpu_sync[1] & cpu_sync[2];
   assign decide   = dly[ADDR_DLY-1];
   assign hs_ok    = shs_sync[1] & ~sls_sync[1];
   assign ls_ok    = sls_sync[1] & ~shs_sync[1];

   assign page  = addr_ip[15:8];
   assign valid = vda_ip | vpa_ip;
   assign fast  = himem_ip | (shadow_en_ip & (page < RAM_TOP_PAGE));
   assign io    = ~himem_ip & (page >= IO_PAGE_LO) & (page <= 8'hFE);

   assign unused_addr = ^addr_ip[7:0];

   assign state_op = state;

   // Synchronise async inputs and time the decode point after cpu_ck falls.
   always_ff @(posedge hs_ck_ip or negedge resetb) begin
      if (!resetb) begin
         ls_sync    <= '0;
         cpu_sync   <= '0;
         shs_sync   <= '0;
         sls_sync   <= '0;
         cpu_fall_r <= 1'b0;
         dly        <= '0;
      end else begin
         ls_sync    <= {ls_sync[1:0], ls_ck_ip};
         cpu_sync   <= {cpu_sync[1:0], cpu_ck_ip};
         shs_sync   <= {shs_sync[0], selected_hs_ip};
         sls_sync   <= {sls_sync[0], selected_ls_ip};
         cpu_fall_r <= cpu_fall;
         dly        <= (dly << 1) | ADDR_DLY'(cpu_fall_r);
      end
   end

   // Switch FSM with registered request, ready, dwell and timeout state.
   always_ff @(posedge hs_ck_ip or negedge resetb) begin
      if (!resetb) begin
         state         <= LS_RUN;
         select_hs_op  <= 1'b0;
         rdy_op        <= 1'b1;
         switch_err_op <= 1'b0;
         hold_cnt      <= '0;
         tcnt          <= '0;
         io_l          <= 1'b0;
      end else begin
         if (ls_rise && hold_cnt != '0)
            hold_cnt <= hold_cnt - 1'b1;
         tcnt <= '0;
         unique case (state)
            LS_RUN: begin
               if (decide && valid) begin
                  if (io) begin
                     hold_cnt <= HOLD_IO;
                  end else if (fast && hold_cnt == '0) begin
                     state        <= TO_HS;
                     select_hs_op <= 1'b1;
                     rdy_op       <= 1'b0;
                  end
               end
            end
            HS_RUN: begin
               if (decide && valid && !fast) begin
                  state        <= TO_LS;
                  select_hs_op <= 1'b0;
                  rdy_op       <= 1'b0;
                  io_l         <= io;
               end
            end
            TO_HS: begin
               if (hs_ok) begin
                  state  <= HS_RUN;
                  rdy_op <= 1'b1;
               end else if (tcnt == TO_LAST) begin
                  state         <= LS_RUN;
                  select_hs_op  <= 1'b0;
                  rdy_op        <= 1'b1;
                  switch_err_op <= 1'b1;
                  hold_cnt      <= HOLD_LS;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            TO_LS: begin
               if (ls_ok) begin
                  state    <= LS_RUN;
                  rdy_op   <= 1'b1;
                  hold_cnt <= io_l ? HOLD_TOP : HOLD_LS;
               end else if (tcnt == TO_LAST) begin
                  state         <= LS_RUN;
                  select_hs_op  <= 1'b0;
                  rdy_op        <= 1'b1;
                  switch_err_op <= 1'b1;
                  hold_cnt      <= HOLD_LS;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/clock_select_ctrl.md
# clock_select_ctrl

Clock-select controller directly upstream of the HS/LS clock switch. Decodes each CPU bus cycle and drives the switch's `select_hs` request. Synchronises the switch's `selected_hs`/`selected_ls` status back into its own domain and stalls the CPU via `rdy` until a requested switch is confirmed. Enforces a minimum dwell on the host (LS) clock after I/O accesses and recovers from a stuck switch with a timeout.

## Interface
Parameters:
- `RAM_TOP_PAGE`, 8'h80: pages below this are fast RAM when `shadow_en_ip`=1.
- `IO_PAGE_LO`, 8'hFC: pages `IO_PAGE_LO`..8'hFE are host I/O.
- `LS_MIN`, 1: minimum LS clock rising edges spent on LS before returning to HS.
- `IO_HOLD`, 2: LS rising edges to dwell on LS after an I/O access.
- `ADDR_DLY`, 2: hs_ck cycles after detected cpu_ck fall before decode is sampled.
- `TIMEOUT`, 255: hs_ck cycles allowed for a switch to confirm.

Ports:
- `hs_ck_ip` in 1: free-running fast clock; all state is on its rising edge.
- `resetb` in 1: reset, asynchronous, active-low.
- `ls_ck_ip` in 1: host clock (async; synchronised).
- `cpu_ck_ip` in 1: switched CPU clock (async; synchronised).
- `addr_ip` in 16: CPU address.
- `vda_ip`, `vpa_ip` in 1: valid data/program address.
- `himem_ip` in 1: access is to high (fast) memory.
- `shadow_en_ip` in 1: enables fast RAM below `RAM_TOP_PAGE`.
- `selected_hs_ip`, `selected_ls_ip` in 1: switch status (async; synchronised).
- `select_hs_op` out 1: request to switch; 1 = HS.
- `rdy_op` out 1: CPU ready; 0 stalls.
- `state_op` out 2: FSM state.
- `switch_err_op` out 1: sticky timeout flag.

## Operation
- Decode at decision point:
  - valid = `vda_ip`|`vpa_ip`.
  - fast = `himem_ip` | (`shadow_en_ip` & `addr_ip[15:8]` < `RAM_TOP_PAGE`).
  - io = !`himem_ip` & `addr_ip[15:8]` in [`IO_PAGE_LO`, 8'hFE].
  - Otherwise the access is host.
  - Invalid cycles never request a switch.
- `hold_cnt`: decrements, saturating at 0, on each synchronised ls_ck rising edge in every state.
- States (`state_op`): HS_RUN=0, TO_LS=1, LS_RUN=2, TO_HS=3.
  - LS_RUN:
    - valid io access reloads `hold_cnt`=`IO_HOLD`.
    - valid fast access with `hold_cnt`==0 -> TO_HS; `select_hs_op`=1, `rdy_op`=0.
    - fast access with `hold_cnt`!=0 stays on LS; no stall.
  - TO_HS: sync `selected_hs`=1 & sync `selected_ls`=0 -> HS_RUN, `rdy_op`=1.
  - HS_RUN: valid non-fast access -> TO_LS; `select_hs_op`=0, `rdy_op`=0. Latch whether the access was io.
  - TO_LS: sync `selected_ls`=1 & sync `selected_hs`=0 -> LS_RUN, `rdy_op`=1. Load `hold_cnt` = io ? max(`LS_MIN`,`IO_HOLD`) : `LS_MIN`.
- Decisions arriving in TO_HS/TO_LS are ignored; a switch always completes or times out first.
- Timeout: a counter runs in TO_HS/TO_LS.
  - Reaching `TIMEOUT` -> LS_RUN, `select_hs_op`=0, `rdy_op`=1, `switch_err_op`=1, `hold_cnt`=`LS_MIN`.
  - `switch_err_op` clears only on reset.
  - Timeout counter width is ceil(log2(`TIMEOUT`+1)); it clears on every state entry.
- Reset values: state LS_RUN (2), `select_hs_op`=0, `rdy_op`=1, `switch_err_op`=0, `hold_cnt`=0, synchronisers 0.

## Timing
- Two-flop synchronisers on `ls_ck_ip`, `cpu_ck_ip`, `selected_hs_ip`, `selected_ls_ip`. A third flop provides edge detect on `ls_ck_ip` and `cpu_ck_ip`.
- Decision point: `ADDR_DLY` hs cycles after the registered cpu_ck falling-edge detect. This is 3+`ADDR_DLY` hs edges after the actual fall. One decision per CPU cycle.
- `select_hs_op`, `rdy_op` and `state_op` are registered and change on the hs edge following the decision.
- Confirm latency: 2 hs cycles of sync, then outputs update on the next edge.
- Simultaneous ls_ck edge and io reload: the reload wins.
- Async reset mid-switch forces reset values immediately; no glitch on `select_hs_op` beyond the single transition to 0.

## Test plan
- Reset: assert `resetb`=0 -> `state_op`=2, `select_hs_op`=0, `rdy_op`=1, `switch_err_op`=0.
- LS->HS: LS_RUN, `hold_cnt`=0, `shadow_en_ip`=1, addr 0x1234, vda=1 -> `select_hs_op`=1, `rdy_op`=0. Model asserts `selected_hs` 5 cycles later -> `rdy_op`=1 three hs edges later, `state_op`=0.
- I/O dwell: HS_RUN, addr 0xFE40 -> TO_LS, confirm -> LS_RUN with `hold_cnt`=2. Fast accesses before 2 ls_ck edges keep `select_hs_op`=0 with `rdy_op`=1. The first fast access after them switches to HS.
- Timeout: TO_HS with status never confirming -> after 255 hs cycles `switch_err_op`=1, `select_hs_op`=0, `state_op`=2, `rdy_op`=1.
- Invalid cycles: HS_RUN, vda=vpa=0, addr 0xFE00 for 10 CPU cycles -> no state change, `rdy_op` stays 1.
- Reset mid TO_HS -> all outputs return to reset values within the same hs cycle.
